ps2_kbd_ctrl: RTL and testbench

Sequencing controller behind the PS/2 byte receiver. It consumes the receiver's one-cycle byte/valid/error strobes and decodes Set-2 scan code sequences (E0, F0 and E1 prefixes). It tracks the Shift and Ctrl modifier state and queues complete key events in a small first-word-fall-through FIFO for the keyboard-matrix logic. It also provides prefix-timeout recovery and a saturating error counter.

---
 rtl/ps2_kbd_ctrl_if.sv | 22 ++
 rtl/ps2_kbd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_ctrl_if.sv
// ps2_kbd_ctrl_if
//   Key-event stream between the PS/2 sequencing controller and the
//   keyboard-matrix logic.
//   EV_CODE  : scan code of the head event
//   EV_EXT   : head event was E0- or E1-prefixed
//   EV_BREAK : head event is a key release
//   EV_VALID : an event is available (FIFO non-empty)
//   EV_READY : consumer accepts the head event this cycle
//   master   : event producer (the controller)
//   slave    : event consumer
interface ps2_kbd_ctrl_if;
  logic [7:0] EV_CODE;
  logic       EV_EXT;
  logic       EV_BREAK;
  logic       EV_VALID;
  logic       EV_READY;

  modport master (output EV_CODE, output EV_EXT, output EV_BREAK,
                  output EV_VALID, input EV_READY);
  modport slave  (input EV_CODE, input EV_EXT, input EV_BREAK,
                  input EV_VALID, output EV_READY);
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl
//   Decodes Set-2 scan code sequences (E0 / F0 / E1 prefixes) coming from
//   the PS/2 byte receiver, tracks Shift/Ctrl state and queues complete key
//   events in a first-word-fall-through FIFO.
//   CLK, nRESET       : clock, asynchronous active-low reset
//   RX_DATA/RX_VALID  : received byte and its one-cycle strobe
//   RX_ERROR          : one-cycle receive error strobe
//   ev                : key-event stream (master side)
//   OVERFLOW          : one-cycle pulse when an event is dropped (FIFO full)
//   SHIFT_HELD        : either Shift key held
//   CTRL_HELD         : either Ctrl key held
//   ERR_COUNT         : saturating count of stream errors
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2000000
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  input  logic                  RX_ERROR,
  ps2_kbd_ctrl_if.master        ev,
  output logic                  OVERFLOW,
  output logic                  SHIFT_HELD,
  output logic                  CTRL_HELD,
  output logic [7:0]            ERR_COUNT
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam logic [23:0] TMO = 24'(TIMEOUT);

  typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_SKIP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [23:0] tmr_q, tmr_d;
  logic [7:0]  err_q, err_d;
  logic        lsh_q, lsh_d, rsh_q, rsh_d, lctl_q, lctl_d, rctl_q, rctl_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [9:0]  head;
  logic        push, push_ext, push_brk, err_inc;
  logic [7:0]  push_code;
  logic        empty, full, pop, wr_en;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && ev.EV_READY;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    lsh_d     = lsh_q;
    rsh_d     = rsh_q;
    lctl_d    = lctl_q;
    rctl_d    = rctl_q;
    push      = 1'b0;
    push_code = RX_DATA;
    push_ext  = 1'b0;
    push_brk  = 1'b0;
    err_inc   = 1'b0;

    if (state_q != ST_IDLE) tmr_d = tmr_q + 24'd1;

    // An error strobe outranks a coincident byte.
    if (RX_ERROR) begin
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end else if (RX_VALID) begin
      case (state_q)
        ST_IDLE: begin
          case (RX_DATA)
            8'hE0: state_d = ST_E0;
            8'hF0: state_d = ST_F0;
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hFF: err_inc = 1'b1;
            8'hAA: begin
              lsh_d  = 1'b0;
              rsh_d  = 1'b0;
              lctl_d = 1'b0;
              rctl_d = 1'b0;
            end
            8'hFA, 8'hEE, 8'hFE, 8'hFC: ;
            default: push = 1'b1;
          endcase
        end
        ST_E0: begin
          if (RX_DATA == 8'hF0) begin
            state_d = ST_E0F0;
          end else begin
            push     = 1'b1;
            push_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_F0: begin
          push     = 1'b1;
          push_brk = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_E0F0: begin
          push     = 1'b1;
          push_ext = 1'b1;
          push_brk = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          // Pause: the seven bytes after E1 collapse into one event.
          if (skip_q == 3'd1) begin
            push      = 1'b1;
            push_code = 8'hE1;
            push_ext  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmr_q >= TMO) begin
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end

    if (RX_VALID || state_d == ST_IDLE) tmr_d = 24'd0;
    if (err_inc) err_d = sat_inc(err_q);

    // Modifiers follow every decoded event, even one the FIFO drops.
    if (push) begin
      if (!push_ext && push_code == 8'h12) lsh_d  = !push_brk;
      if (!push_ext && push_code == 8'h59) rsh_d  = !push_brk;
      if (!push_ext && push_code == 8'h14) lctl_d = !push_brk;
      if ( push_ext && push_code == 8'h14) rctl_d = !push_brk;
    end

    // A pop in the same cycle frees the slot for a push into a full FIFO.
    wr_en  = push && (!full || pop);
    ovf_d  = push && full && !pop;
    wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      skip_q  <= 3'd0;
      tmr_q   <= 24'd0;
      err_q   <= 8'd0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      lctl_q  <= 1'b0;
      rctl_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      lctl_q  <= lctl_d;
      rctl_q  <= rctl_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= {push_code, push_ext, push_brk};
  end

  // Outputs are forced to zero when empty so nothing stale shows after reset.
  assign head        = mem[rptr_q[AW-1:0]];
  assign ev.EV_VALID = !empty;
  assign ev.EV_CODE  = empty ? 8'h00 : head[9:2];
  assign ev.EV_EXT   = !empty && head[1];
  assign ev.EV_BREAK = !empty && head[0];

  assign OVERFLOW   = ovf_q;
  assign SHIFT_HELD = lsh_q | rsh_q;
  assign CTRL_HELD  = lctl_q | rctl_q;
  assign ERR_COUNT  = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl
//   Directed bench for ps2_kbd_ctrl. Expected events are queued when their
//   final byte is sent; a monitor compares each event as it is accepted.
module tb_ps2_kbd_ctrl;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic       RX_ERROR = 1'b0;
  logic       OVERFLOW, SHIFT_HELD, CTRL_HELD;
  logic [7:0] ERR_COUNT;

  ps2_kbd_ctrl_if evif();

  ps2_kbd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(40)) dut (
    .CLK(CLK), .nRESET(nRESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_ERROR(RX_ERROR), .ev(evif), .OVERFLOW(OVERFLOW),
    .SHIFT_HELD(SHIFT_HELD), .CTRL_HELD(CTRL_HELD), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_DATA = b; RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic send_err(input logic with_byte, input logic [7:0] b);
    @(posedge CLK); #1;
    RX_ERROR = 1'b1; RX_VALID = with_byte; RX_DATA = b;
    @(posedge CLK); #1;
    RX_ERROR = 1'b0; RX_VALID = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({code, ext, brk});
  endtask

  task automatic drain(input string name);
    bit done = 0;
    @(posedge CLK); #1;
    evif.EV_READY = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0 && !evif.EV_VALID) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_%s: pending=%0d ev_valid=%0b expected 0 0",
               name, exp_q.size(), evif.EV_VALID);
    end
  endtask

  // Monitor: an event is consumed on the edge after a negedge that sees VALID & READY.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRESET && evif.EV_VALID && evif.EV_READY) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ev_unexpected: got %h expected none",
                   {evif.EV_CODE, evif.EV_EXT, evif.EV_BREAK});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({evif.EV_CODE, evif.EV_EXT, evif.EV_BREAK} !== e) begin
            bad++;
            $display("FAIL ev: got code=%h ext=%0b brk=%0b expected code=%h ext=%0b brk=%0b",
                     evif.EV_CODE, evif.EV_EXT, evif.EV_BREAK, e[9:2], e[1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    evif.EV_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ev_valid", evif.EV_VALID, 0);
    chk("rst_err", ERR_COUNT, 0);
    chk("rst_shift", SHIFT_HELD, 0);
    chk("rst_ctrl", CTRL_HELD, 0);
    chk("rst_ovf", OVERFLOW, 0);
    @(negedge CLK);
    nRESET = 1'b1;

    // Make and break with one-cycle latency
    send(8'h1C); expect_ev(8'h1C, 0, 0);
    chk("latency_make", evif.EV_VALID, 1);
    send(8'hF0);
    send(8'h1C); expect_ev(8'h1C, 0, 1);
    drain("make_break");

    // Extended codes and modifiers
    send(8'hE0); send(8'h75); expect_ev(8'h75, 1, 0);
    send(8'hE0); send(8'hF0); send(8'h75); expect_ev(8'h75, 1, 1);
    send(8'h12); expect_ev(8'h12, 0, 0);
    chk("shift_l_make", SHIFT_HELD, 1);
    send(8'h59); expect_ev(8'h59, 0, 0);
    chk("shift_r_make", SHIFT_HELD, 1);
    send(8'hF0); send(8'h12); expect_ev(8'h12, 0, 1);
    chk("shift_l_break", SHIFT_HELD, 1);
    send(8'hF0); send(8'h59); expect_ev(8'h59, 0, 1);
    chk("shift_r_break", SHIFT_HELD, 0);
    send(8'hE0); send(8'h12); expect_ev(8'h12, 1, 0);
    chk("shift_e0_12", SHIFT_HELD, 0);
    send(8'hE0); send(8'h14); expect_ev(8'h14, 1, 0);
    chk("rctrl_make", CTRL_HELD, 1);
    send(8'hE0); send(8'hF0); send(8'h14); expect_ev(8'h14, 1, 1);
    chk("rctrl_break", CTRL_HELD, 0);
    send(8'h14); expect_ev(8'h14, 0, 0);
    send(8'h12); expect_ev(8'h12, 0, 0);
    chk("lctrl_make", CTRL_HELD, 1);
    send(8'hAA);
    chk("bat_clr_shift", SHIFT_HELD, 0);
    chk("bat_clr_ctrl", CTRL_HELD, 0);
    send(8'hFA);
    drain("ext_mod");

    // Pause sequence collapses to one event
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_ev(8'hE1, 1, 0);
    chk("pause_ctrl", CTRL_HELD, 0);
    drain("pause");

    // Prefix timeout
    send(8'hE0);
    repeat (60) @(posedge CLK);
    #1;
    chk("timeout_err", ERR_COUNT, 1);
    chk("timeout_noev", evif.EV_VALID, 0);
    send(8'h1C); expect_ev(8'h1C, 0, 0);
    drain("timeout");
    send(8'h00);
    chk("overrun_err", ERR_COUNT, 2);

    // FIFO overflow and push/pop while full
    evif.EV_READY = 1'b0;
    send(8'h21); expect_ev(8'h21, 0, 0);
    send(8'h22); expect_ev(8'h22, 0, 0);
    send(8'h23); expect_ev(8'h23, 0, 0);
    send(8'h24); expect_ev(8'h24, 0, 0);
    chk("ovf_4th", OVERFLOW, 0);
    send(8'h25);
    chk("ovf_5th", OVERFLOW, 1);
    @(posedge CLK); #1;
    chk("ovf_pulse", OVERFLOW, 0);
    @(posedge CLK); #1;
    RX_DATA = 8'h26; RX_VALID = 1'b1; evif.EV_READY = 1'b1;
    expect_ev(8'h26, 0, 0);
    @(posedge CLK); #1;
    RX_VALID = 1'b0; evif.EV_READY = 1'b0;
    chk("ovf_pushpop", OVERFLOW, 0);
    chk("full_valid", evif.EV_VALID, 1);
    drain("overflow");

    // Error counter saturation and error handling
    for (int i = 0; i < 300; i++) send_err(1'b0, 8'h00);
    chk("err_sat", ERR_COUNT, 255);
    send_err(1'b1, 8'h1C);
    repeat (3) @(posedge CLK);
    #1;
    chk("err_wins", evif.EV_VALID, 0);
    send(8'hF0);
    send_err(1'b0, 8'h00);
    send(8'h1C); expect_ev(8'h1C, 0, 0);
    chk("err_sat_hold", ERR_COUNT, 255);
    drain("errors");

    // Reset mid-sequence with a non-empty FIFO
    evif.EV_READY = 1'b0;
    send(8'h12); send(8'h1C); send(8'hE0);
    chk("pre_rst_shift", SHIFT_HELD, 1);
    #3 nRESET = 1'b0;
    #1;
    chk("mid_rst_valid", evif.EV_VALID, 0);
    chk("mid_rst_shift", SHIFT_HELD, 0);
    chk("mid_rst_err", ERR_COUNT, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    send(8'h75); expect_ev(8'h75, 0, 0);
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
